mc_mod_scheduler: RTL and testbench

Modulation scheduler for the 3x3 matrix converter. It drives `top_commutation` each switching period. Per output phase, it turns two programmed switch instants into the `DesiredLoad` code (input A, then B, then C). It enforces a minimum dwell per phase so the commutation sequence always completes, and it latches a fault on `short`, forcing all loads to NUL.

---
 rtl/mc_pkg.sv | 32 +++
 rtl/mc_phase_sched.sv | 59 +++++
 rtl/mc_mod_scheduler.sv | 159 +++++++++++++++
 tb/tb_mc_mod_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and constants for the 3x3 matrix-converter modulation scheduler
// and the commutation block it feeds.
package mc_pkg;

    typedef enum logic [1:0] {
        LOAD_NUL = 2'b00,
        LOAD_AA  = 2'b01,
        LOAD_BB  = 2'b10,
        LOAD_CC  = 2'b11
    } load_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_e;

    // Gate patterns for one output phase: a bidirectional switch (two devices) per input phase.
    localparam logic [5:0] SAA = 6'b000011;
    localparam logic [5:0] SBB = 6'b001100;
    localparam logic [5:0] SCC = 6'b110000;

    function automatic logic [5:0] load_pattern(input load_e ld);
        case (ld)
            LOAD_AA: load_pattern = SAA;
            LOAD_BB: load_pattern = SBB;
            LOAD_CC: load_pattern = SCC;
            default: load_pattern = 6'b000000;
        endcase
    endfunction

endpackage

// File: rtl/mc_phase_sched.sv
// One output phase: clamps the switch instants, picks the target input and holds each
// load for MIN_DWELL cycles; load is registered one cycle behind the cnt that selected it.
module mc_phase_sched
    import mc_pkg::*;
#(
    parameter int CNT_W     = 12,
    parameter int MIN_DWELL = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [CNT_W-1:0] t1_i,
    input  logic [CNT_W-1:0] t2_i,
    input  logic [CNT_W-1:0] period_i,
    output load_e            load_o
);

    localparam int DW_W = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;

    logic [CNT_W-1:0] t1c;
    logic [CNT_W-1:0] t2_lim;
    logic [CNT_W-1:0] t2c;
    load_e            target;
    load_e            load_q;
    logic [DW_W-1:0]  dwell_q;

    assign t1c    = (t1_i < period_i) ? t1_i : period_i;
    assign t2_lim = (t2_i < period_i) ? t2_i : period_i;
    assign t2c    = (t2_lim > t1c) ? t2_lim : t1c;

    always_comb begin
        target = LOAD_CC;
        if (cnt_i < t1c) begin
            target = LOAD_AA;
        end else if (cnt_i < t2c) begin
            target = LOAD_BB;
        end
    end

    // Requests arriving mid-dwell are not queued; whatever the target is when dwell expires wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_q  <= LOAD_NUL;
            dwell_q <= '0;
        end else if (!run_i) begin
            load_q  <= LOAD_NUL;
            dwell_q <= '0;
        end else if ((target != load_q) && (dwell_q == '0)) begin
            load_q  <= target;
            dwell_q <= DW_W'(MIN_DWELL - 1);
        end else if (dwell_q != '0) begin
            dwell_q <= dwell_q - DW_W'(1);
        end
    end

    assign load_o = load_q;

endmodule

// File: rtl/mc_mod_scheduler.sv
// Period counter, double-buffered config and run/fault FSM driving three phase schedulers.
// All outputs registered; config accepted only while the shadow slot is empty.
module mc_mod_scheduler
    import mc_pkg::*;
#(
    parameter int CNT_W     = 12,
    parameter int MIN_DWELL = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [3*CNT_W-1:0] cfg_t1,
    input  logic [3*CNT_W-1:0] cfg_t2,
    input  logic               short,
    input  logic               fault_clr,
    output logic               start,
    output logic [5:0]         desired_load,
    output logic               period_start,
    output logic               cfg_miss,
    output logic               fault
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   act_period_q;
    logic [3*CNT_W-1:0] act_t1_q;
    logic [3*CNT_W-1:0] act_t2_q;
    logic [CNT_W-1:0]   shd_period_q;
    logic [3*CNT_W-1:0] shd_t1_q;
    logic [3*CNT_W-1:0] shd_t2_q;
    logic               shd_full_q;
    logic               shd_full_d;
    logic               cfg_ready_q;
    logic               start_q;
    logic               period_start_q;
    logic               cfg_miss_q;
    logic               fault_q;
    logic               cfg_xfer;
    logic               wrap;
    logic               run_en;

    assign cfg_xfer = cfg_valid && cfg_ready_q;
    assign wrap     = (cnt_q == act_period_q - CNT_W'(1));
    // Dropping run on the same edge that leaves RUN keeps start and the loads aligned with the state.
    assign run_en   = (state_q == RUN) && enable && !short;
    // A wrap empties the shadow before a same-cycle transfer refills it.
    assign shd_full_d = (wrap ? 1'b0 : shd_full_q) || cfg_xfer;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            act_period_q   <= '0;
            act_t1_q       <= '0;
            act_t2_q       <= '0;
            shd_period_q   <= '0;
            shd_t1_q       <= '0;
            shd_t2_q       <= '0;
            shd_full_q     <= 1'b0;
            cfg_ready_q    <= 1'b0;
            start_q        <= 1'b0;
            period_start_q <= 1'b0;
            cfg_miss_q     <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            start_q        <= run_en;
            period_start_q <= 1'b0;
            cfg_miss_q     <= 1'b0;
            if (short) begin
                state_q     <= FAULT;
                cnt_q       <= '0;
                shd_full_q  <= 1'b0;
                cfg_ready_q <= 1'b0;
                fault_q     <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        cfg_ready_q <= 1'b1;
                        if (cfg_xfer && enable) begin
                            act_period_q   <= cfg_period;
                            act_t1_q       <= cfg_t1;
                            act_t2_q       <= cfg_t2;
                            cnt_q          <= '0;
                            period_start_q <= 1'b1;
                            state_q        <= RUN;
                        end
                    end
                    RUN: begin
                        if (!enable) begin
                            state_q     <= IDLE;
                            cnt_q       <= '0;
                            shd_full_q  <= 1'b0;
                            cfg_ready_q <= 1'b1;
                        end else begin
                            if (wrap) begin
                                cnt_q          <= '0;
                                period_start_q <= 1'b1;
                                if (shd_full_q) begin
                                    act_period_q <= shd_period_q;
                                    act_t1_q     <= shd_t1_q;
                                    act_t2_q     <= shd_t2_q;
                                end else begin
                                    cfg_miss_q <= 1'b1;
                                end
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                            if (cfg_xfer) begin
                                shd_period_q <= cfg_period;
                                shd_t1_q     <= cfg_t1;
                                shd_t2_q     <= cfg_t2;
                            end
                            shd_full_q  <= shd_full_d;
                            cfg_ready_q <= !shd_full_d;
                        end
                    end
                    FAULT: begin
                        cfg_ready_q <= 1'b0;
                        if (fault_clr) begin
                            state_q     <= IDLE;
                            fault_q     <= 1'b0;
                            cfg_ready_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    load_e load [3];

    for (genvar i = 0; i < 3; i++) begin : g_phase
        mc_phase_sched #(
            .CNT_W     (CNT_W),
            .MIN_DWELL (MIN_DWELL)
        ) u_phase (
            .clk      (clk),
            .rst      (rst),
            .run_i    (run_en),
            .cnt_i    (cnt_q),
            .t1_i     (act_t1_q[(3-i)*CNT_W-1 -: CNT_W]),
            .t2_i     (act_t2_q[(3-i)*CNT_W-1 -: CNT_W]),
            .period_i (act_period_q),
            .load_o   (load[i])
        );
    end

    assign desired_load = {load[0], load[1], load[2]};
    assign cfg_ready    = cfg_ready_q;
    assign start        = start_q;
    assign period_start = period_start_q;
    assign cfg_miss     = cfg_miss_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_mc_mod_scheduler.sv
// Scoreboard bench for mc_mod_scheduler: expectations are queued against absolute
// cycle numbers while stimulus is driven and compared on the falling edge.
module tb_mc_mod_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [11:0] cfg_period;
    logic [35:0] cfg_t1;
    logic [35:0] cfg_t2;
    logic        short;
    logic        fault_clr;
    logic        start;
    logic [5:0]  desired_load;
    logic        period_start;
    logic        cfg_miss;
    logic        fault;

    mc_mod_scheduler #(.CNT_W(12), .MIN_DWELL(40)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_period   (cfg_period),
        .cfg_t1       (cfg_t1),
        .cfg_t2       (cfg_t2),
        .short        (short),
        .fault_clr    (fault_clr),
        .start        (start),
        .desired_load (desired_load),
        .period_start (period_start),
        .cfg_miss     (cfg_miss),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [11:0] act, input logic [11:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef enum int {S_DL, S_START, S_PS, S_MISS, S_FAULT, S_RDY} sig_e;
    typedef struct {
        int          cyc;
        sig_e        sel;
        logic [11:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];

    function automatic void expect_at(input int c, input sig_e s, input logic [11:0] v, input string tag);
        exp_t e;
        int   idx;
        e.cyc = c;
        e.sel = s;
        e.val = v;
        e.tag = tag;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > c) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endfunction

    function automatic logic [11:0] obs(input sig_e s);
        case (s)
            S_DL:    obs = 12'(desired_load);
            S_START: obs = 12'(start);
            S_PS:    obs = 12'(period_start);
            S_MISS:  obs = 12'(cfg_miss);
            S_FAULT: obs = 12'(fault);
            default: obs = 12'(cfg_ready);
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc != cyc) chk("stale", 12'(e.cyc), 12'(cyc));
            else              chk(e.tag, obs(e.sel), e.val);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain", 12'(sb.size()), 12'd0);
    endtask

    task automatic accept(input logic [11:0] per, input logic [35:0] t1, input logic [35:0] t2,
                          output int acc);
        cfg_period = per;
        cfg_t1     = t1;
        cfg_t2     = t2;
        enable     = 1'b1;
        cfg_valid  = 1'b1;
        chk("acc_rdy", 12'(cfg_ready), 12'd1);
        tick();
        acc       = cyc;
        cfg_valid = 1'b0;
    endtask

    localparam logic [35:0] A_T1 = {12'd50, 12'd50, 12'd50};
    localparam logic [35:0] A_T2 = {12'd120, 12'd120, 12'd120};
    localparam logic [35:0] B_T1 = {12'd10, 12'd300, 12'd60};
    localparam logic [35:0] B_T2 = {12'd20, 12'd400, 12'd30};

    initial begin
        int acc;
        int p;
        int f;
        int c0;
        rst = 1'b0; enable = 1'b0; cfg_valid = 1'b0; short = 1'b0; fault_clr = 1'b0;
        cfg_period = '0; cfg_t1 = '0; cfg_t2 = '0;
        #3;
        chk("rst_start", 12'(start), 12'd0);
        chk("rst_dl", 12'(desired_load), 12'd0);
        chk("rst_ready", 12'(cfg_ready), 12'd0);
        chk("rst_fault", 12'(fault), 12'd0);
        tick(); tick();
        rst = 1'b1;
        chk("rel_ready0", 12'(cfg_ready), 12'd0);
        tick();
        chk("rel_ready1", 12'(cfg_ready), 12'd1);

        // Config A, two periods; shadow loaded with config B during the second.
        accept(12'd200, A_T1, A_T2, acc);
        expect_at(acc,       S_PS,    12'd1,   "entry_ps");
        expect_at(acc,       S_MISS,  12'd0,   "entry_miss");
        expect_at(acc + 1,   S_DL,    12'h15,  "first_aa");
        expect_at(acc + 1,   S_START, 12'd1,   "first_start");
        expect_at(acc + 50,  S_DL,    12'h15,  "aa_c50");
        expect_at(acc + 51,  S_DL,    12'h2A,  "bb_c51");
        expect_at(acc + 120, S_DL,    12'h2A,  "bb_c120");
        expect_at(acc + 121, S_DL,    12'h3F,  "cc_c121");
        expect_at(acc + 199, S_PS,    12'd0,   "ps_low");
        expect_at(acc + 200, S_PS,    12'd1,   "wrap1_ps");
        expect_at(acc + 200, S_MISS,  12'd1,   "wrap1_miss");
        expect_at(acc + 200, S_DL,    12'h3F,  "wrap1_cc");
        expect_at(acc + 201, S_DL,    12'h15,  "wrap1_aa");
        expect_at(acc + 201, S_MISS,  12'd0,   "miss_pulse");
        expect_at(acc + 210, S_RDY,   12'd1,   "shd_ready");
        expect_at(acc + 251, S_DL,    12'h2A,  "rep_bb");
        wait_cyc(acc + 210);
        cfg_period = 12'd200; cfg_t1 = B_T1; cfg_t2 = B_T2; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        expect_at(acc + 211, S_RDY,   12'd0,   "shd_full");
        expect_at(acc + 399, S_RDY,   12'd0,   "shd_block");
        expect_at(acc + 399, S_DL,    12'h3F,  "p2_end_cc");
        expect_at(acc + 400, S_RDY,   12'd1,   "shd_free");
        expect_at(acc + 400, S_PS,    12'd1,   "wrap2_ps");
        expect_at(acc + 400, S_MISS,  12'd0,   "wrap2_nomiss");

        // Config B: dwell-deferred CC on phase 0, AA-only phase 1, BB-skipping phase 2.
        p = acc + 400;
        expect_at(p + 1,   S_DL, 12'h15, "b_aa");
        expect_at(p + 15,  S_DL, 12'h15, "b_bb_drop15");
        expect_at(p + 25,  S_DL, 12'h15, "b_bb_drop25");
        expect_at(p + 40,  S_DL, 12'h15, "b_dwell_hold");
        expect_at(p + 41,  S_DL, 12'h35, "b_cc_ph0");
        expect_at(p + 60,  S_DL, 12'h35, "b_ph2_aa");
        expect_at(p + 61,  S_DL, 12'h37, "b_ph2_cc");
        expect_at(p + 200, S_PS, 12'd1,  "wrap3_ps");
        expect_at(p + 200, S_MISS, 12'd1, "wrap3_miss");
        expect_at(p + 201, S_DL, 12'h15, "b_rep_aa");
        expect_at(p + 241, S_DL, 12'h35, "b_rep_cc_ph0");

        // Short for one cycle mid-period, then both fault_clr cases.
        f = p + 280;
        expect_at(f - 1, S_DL,    12'h37, "pre_fault_dl");
        expect_at(f - 1, S_START, 12'd1,  "pre_fault_start");
        wait_cyc(f - 1);
        expect_at(f, S_DL,    12'd0, "fault_dl");
        expect_at(f, S_START, 12'd0, "fault_start");
        expect_at(f, S_FAULT, 12'd1, "fault_set");
        expect_at(f, S_RDY,   12'd0, "fault_ready");
        short = 1'b1;
        tick();
        short = 1'b0;
        expect_at(f + 3, S_FAULT, 12'd1, "fault_held");
        expect_at(f + 3, S_START, 12'd0, "fault_start_held");
        wait_cyc(f + 5);
        fault_clr = 1'b1; short = 1'b1;
        expect_at(f + 6, S_FAULT, 12'd1, "clr_blocked");
        tick();
        short = 1'b0;
        expect_at(f + 7, S_FAULT, 12'd0, "clr_fault");
        expect_at(f + 7, S_RDY,   12'd1, "clr_ready");
        expect_at(f + 7, S_START, 12'd0, "clr_start");
        tick();
        fault_clr = 1'b0;
        drain(20);

        // Asynchronous reset mid-period, then restart and enable drop.
        accept(12'd200, A_T1, A_T2, acc);
        expect_at(acc + 1,  S_DL, 12'h15, "r_aa");
        expect_at(acc + 60, S_DL, 12'h2A, "r_bb");
        drain(100);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_start", 12'(start), 12'd0);
        chk("arst_dl", 12'(desired_load), 12'd0);
        chk("arst_ready", 12'(cfg_ready), 12'd0);
        chk("arst_ps", 12'(period_start), 12'd0);
        chk("arst_miss", 12'(cfg_miss), 12'd0);
        chk("arst_fault", 12'(fault), 12'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        c0 = cyc;
        expect_at(c0 + 10, S_START, 12'd0, "idle_start");
        expect_at(c0 + 10, S_DL,    12'd0, "idle_dl");
        expect_at(c0 + 10, S_RDY,   12'd1, "idle_ready");
        drain(20);
        accept(12'd200, A_T1, A_T2, acc);
        expect_at(acc + 1, S_DL,    12'h15, "re_aa");
        expect_at(acc + 1, S_START, 12'd1,  "re_start");
        expect_at(acc + 5, S_START, 12'd1,  "en_start");
        wait_cyc(acc + 5);
        enable = 1'b0;
        expect_at(acc + 6, S_START, 12'd0, "dis_start");
        expect_at(acc + 6, S_DL,    12'd0, "dis_dl");
        expect_at(acc + 6, S_RDY,   12'd1, "dis_ready");
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
